// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: captures a pattern, a length and a repeat count,
// then shifts the pattern out MSB-first, one bit per clock, with a valid qualifier.
module serial_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [REP_W-1:0] reps_i,
  input  logic             stop_i,
  output logic             x_o,
  output logic             x_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(WIDTH);
  localparam logic [REP_W-1:0] RepMax = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             len_ok;
  logic             more_reps;
  logic [REP_W:0]   rep_cnt_inc;

  // Select bit idx of a pattern word without an over-wide index select.
  function automatic logic pick_bit(input logic [WIDTH-1:0] word, input logic [LEN_W-1:0] idx);
    logic [WIDTH-1:0] shifted;
    shifted = word >> idx;
    return shifted[0];
  endfunction

  // Length legality and repetition bookkeeping; REP_W+1 bits so the compare never wraps.
  always_comb begin
    len_ok      = (len_i != '0) && (len_i <= MaxLen);
    rep_cnt_inc = {1'b0, rep_cnt_q} + {{REP_W{1'b0}}, 1'b1};
    more_reps   = (reps_q == '0) || (rep_cnt_inc < {1'b0, reps_q});
  end

  // Next-state and registered-output logic; outputs default to the idle values.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    reps_d    = reps_q;
    bit_idx_d = bit_idx_q;
    rep_cnt_d = rep_cnt_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_ok) begin
            pat_d     = data_i;
            len_d     = len_i;
            reps_d    = reps_i;
            bit_idx_d = len_i - 1'b1;
            rep_cnt_d = '0;
            x_d       = pick_bit(data_i, len_i - 1'b1);
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
            state_d   = StShift;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StShift: begin
        if (stop_i) begin
          // Abort beats last-bit completion: no done pulse.
          state_d = StIdle;
        end else if (bit_idx_q != '0) begin
          bit_idx_d = bit_idx_q - 1'b1;
          x_d       = pick_bit(pat_q, bit_idx_q - 1'b1);
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else if (more_reps) begin
          // Seamless reload; in continuous mode the counter saturates instead of wrapping.
          bit_idx_d = len_q - 1'b1;
          if (rep_cnt_q != RepMax) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
          x_d       = pick_bit(pat_q, len_q - 1'b1);
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      len_q     <= '0;
      reps_q    <= '0;
      bit_idx_q <= '0;
      rep_cnt_q <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      reps_q    <= reps_d;
      bit_idx_q <= bit_idx_d;
      rep_cnt_q <= rep_cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign x_o       = x_q;
  assign x_valid_o = x_valid_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: directed and random transfers checked against a
// bit-queue model built directly from data/len/reps.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       x, x_valid, busy, done, err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(
    .WIDTH(8),
    .LEN_W(4),
    .REP_W(4)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .data_i   (data),
    .len_i    (len),
    .reps_i   (reps),
    .stop_i   (stop),
    .x_o      (x),
    .x_valid_o(x_valid),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer. stop_after>0 raises stop so exactly that many bits are sent.
  // hold keeps start high (with junk inputs) during the transfer; b2b returns in the
  // done cycle so the caller can start the next transfer there.
  task automatic send(input logic [7:0] d, input int l, input int r, input int stop_after,
                      input bit hold, input bit b2b);
    bit q[$];
    bit stopped;
    int total;
    stopped = (r == 0) || (stop_after > 0);
    total   = stopped ? stop_after : l * r;
    for (int n = 0; n < total; n++) q.push_back(d[l - 1 - (n % l)]);

    data  = d;
    len   = 4'(l);
    reps  = 4'(r);
    start = 1'b1;
    step();
    for (int n = 0; n < total; n++) begin
      start = hold;
      data  = 8'($urandom);
      len   = 4'($urandom);
      reps  = 4'($urandom);
      check("busy", busy, 1);
      check("x_valid", x_valid, 1);
      check("x_bit", x, q[n]);
      check("done_early", done, 0);
      check("err_busy", err, 0);
      if (stopped && n == total - 1) stop = 1'b1;
      step();
    end
    check("end_busy", busy, 0);
    check("end_x_valid", x_valid, 0);
    check("end_x", x, 0);
    check("end_done", done, stopped ? 0 : 1);
    check("end_err", err, 0);
    stop  = 1'b0;
    start = 1'b0;
    if (!b2b) begin
      step();
      check("done_once", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  task automatic bad_start(input int l);
    data  = 8'($urandom);
    len   = 4'(l);
    reps  = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy0", busy, 0);
    check("err_valid0", x_valid, 0);
    step();
    check("err_once", err, 0);
    check("err_busy1", busy, 0);
  endtask

  initial begin
    int l, r, sa;
    bit hold, b2b;

    // Reset held with start high: nothing happens.
    rst_n = 1'b0;
    start = 1'b1;
    data  = 8'h0A;
    len   = 4'd4;
    reps  = 4'd1;
    step();
    step();
    check("rst_x", x, 0);
    check("rst_x_valid", x_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    send(8'h0A, 4, 1, 0, 0, 0);   // 1010
    send(8'h0A, 4, 2, 0, 0, 0);   // 10101010 contiguous
    send(8'h05, 3, 0, 7, 0, 0);   // continuous 101..., 7 bits then stop
    bad_start(0);
    bad_start(9);
    send(8'hC3, 8, 2, 0, 1, 0);   // start held high throughout
    send(8'hA5, 8, 1, 0, 0, 1);   // back-to-back: next start in done cycle
    send(8'h3C, 6, 1, 0, 0, 0);
    send(8'h01, 1, 3, 0, 0, 0);   // three 1s
    send(8'h0A, 4, 1, 4, 0, 0);   // stop on last bit: no done
    send(8'h01, 1, 0, 40, 0, 0);  // repetition counter saturates, keeps going
    send(8'h02, 2, 15, 0, 0, 0);  // maximum finite repeat count

    for (int i = 0; i < 12; i++) begin
      l    = $urandom_range(1, 8);
      r    = $urandom_range(0, 4);
      if (r == 0) sa = $urandom_range(1, 20);
      else sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, l * r) : 0;
      hold = 1'($urandom_range(0, 1));
      b2b  = 1'($urandom_range(0, 1));
      send(8'($urandom), l, r, sa, hold, b2b);
    end

    // stop while idle is ignored.
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_idle_busy", busy, 0);
    check("stop_idle_done", done, 0);

    // Reset mid-pattern drops outputs without waiting for a clock.
    data  = 8'hFF;
    len   = 4'd8;
    reps  = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("mid_valid_pre", x_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", x_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_x", x, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Programmable serial bit-pattern transmitter. It captures a parallel pattern word, a length and a repeat count, then drives the pattern MSB-first, one bit per clock, on a single serial line with a valid qualifier. It is the stimulus/transmit end for the serial sequence detectors (e.g. `moore_1010`). Its `x` output connects directly to a detector's `x` input on the same clock.

## Interface
- `WIDTH`, 8: maximum pattern length in bits (≥2).
- `LEN_W`, 4: width of `len`; must satisfy 2^LEN_W > WIDTH.
- `REP_W`, 4: width of `reps`.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset. Assertion immediately forces the reset state; deassertion is synchronised externally.
- `start`  in  1  request to transmit; sampled on rising edge.
- `data`  in  WIDTH  pattern; active field is `data[len-1:0]`, sent from bit `len-1` down to bit 0.
- `len`  in  LEN_W  pattern length; legal range 1..WIDTH.
- `reps`  in  REP_W  repetitions; 0 = continuous until `stop`.
- `stop`  in  1  abort request; only honoured while busy.
- `x`  out  1  serial data (registered).
- `x_valid`  out  1  high while `x` carries a pattern bit (registered).
- `busy`  out  1  transmission in progress (registered).
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  one-cycle pulse when `start` is rejected for an illegal `len`.

## Operation
- FSM states:
  - IDLE: `busy=0`, `x_valid=0`, `x=0`.
  - SHIFT: a bit is on `x` every cycle.
- Registers:
  - `pat_q`, `len_q`, `reps_q`: captured at acceptance.
  - `bit_idx`: counts down from `len_q-1` to 0.
  - `rep_cnt`: counts completed repetitions.
- IDLE, `start=1`, `1≤len≤WIDTH`: capture `data`, `len` and `reps`, set `bit_idx=len-1`, go to SHIFT. Inputs may change freely after acceptance.
- IDLE, `start=1`, `len=0` or `len>WIDTH`: stay in IDLE and pulse `err` for one cycle. Nothing is captured.
- SHIFT, `bit_idx>0`: decrement `bit_idx`.
- SHIFT, `bit_idx=0`, more repetitions due (`reps_q=0`, or `rep_cnt+1<reps_q`): reload `bit_idx=len_q-1` and increment `rep_cnt`. There is no gap between repetitions, so "1010"×2 yields a contiguous 10101010.
- SHIFT, `bit_idx=0`, last repetition: go to IDLE and pulse `done`.
- `stop=1` in SHIFT: the bit currently on `x` completes; on the next edge go to IDLE. No `done` pulse.
- `stop` in IDLE is ignored.
- `stop` and last-bit completion in the same cycle: `stop` wins, so no `done`.
- `start` while busy is ignored: not queued, no `err`.
- `rep_cnt` is REP_W wide. In continuous mode it saturates and does not wrap into termination.
- Reset mid-transmission: outputs drop immediately to their reset values; the pattern is lost.
- Reset values: `x=0`, `x_valid=0`, `busy=0`, `done=0`, `err=0`, state IDLE, all internal registers 0.

## Timing
- `start` accepted at edge k: after edge k, `busy=1`, `x_valid=1` and `x=data[len-1]`. Latency is one cycle.
- Bit i of each repetition (i=0 being `data[len-1]`) is driven from edge k+i. The receiver samples it at edge k+i+1.
- Total duration is `len*reps` cycles.
- After edge k+`len*reps`: `busy=0`, `x_valid=0`, `x=0`, `done=1` for exactly one cycle.
- Back-to-back: `start` sampled high in the `done` cycle is accepted, so the next pattern begins one idle cycle after the previous last bit.
- `err` is asserted the cycle after the rejected `start` edge, for one cycle.
- `stop` sampled at edge m in SHIFT: `x_valid=0` and `busy=0` after edge m.

## Test plan
- Reset: drive `rst=0` with `start=1` → all outputs 0. Release `rst`, `start` at next edge → first bit appears one cycle later.
- Basic: `data=8'h0A`, `len=4`, `reps=1` → `x`=1,0,1,0 on 4 consecutive cycles with `x_valid=1`. `done` pulses on cycle 5. A chained `moore_1010` raises `y` once.
- Repeat/overlap: `data=8'h0A`, `len=4`, `reps=2` → `x`=10101010 with no gap, `done` after 8 bits. The chained detector raises `y` 3 times (overlapping detection).
- Continuous and abort: `data=8'h05`, `len=3`, `reps=0` → 101 repeats. Assert `stop` after 7 bits → exactly 7 valid bits, then idle, no `done`.
- Illegal length: `len=0`, then `len=9` (WIDTH=8) → `err` pulse each time, `busy` stays 0.
- Edge cases:
  - `start` held high during a transmission → ignored.
  - `start` in the `done` cycle → the new pattern starts after one idle cycle.
  - `len=1`, `reps=3`, `data[0]=1` → three 1s, then `done`.
  - Reset asserted mid-pattern → `x_valid` drops immediately.
